// File: rtl/brew_order_controller_if.sv
// brew_order_controller_if: coin/button/tick inputs (master drives) and credit/change/valve/status outputs (slave drives)
interface brew_order_controller_if;
  logic       coin_100, coin_500;
  logic [2:0] coffee_type;
  logic       start, cancel, tick;
  logic [3:0] credit, change;
  logic       water, coffee, sugar, milk, chocolate;
  logic       busy, reject, finished;
  modport master (
    output coin_100, coin_500, coffee_type, start, cancel, tick,
    input  credit, change, water, coffee, sugar, milk, chocolate, busy, reject, finished
  );
  modport slave (
    input  coin_100, coin_500, coffee_type, start, cancel, tick,
    output credit, change, water, coffee, sugar, milk, chocolate, busy, reject, finished
  );
endinterface

// File: rtl/brew_order_controller.sv
// brew_order_controller: coin credit, price check and timed recipe valve sequencing; clock/reset (sync active-low) plus bus slave port
module brew_order_controller #(
  parameter int MAX_CREDIT = 15,
  parameter int DONE_TICKS = 2
) (
  input logic clock,
  input logic reset,
  brew_order_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WATER, COFFEE, SUGAR, MILK, CHOC, DONE} state_t;
  state_t     state;
  logic [1:0] ty, cnt, cnt_nxt;
  logic [3:0] price;
  logic [4:0] add_c, add_z;
  logic       valid, afford, hit;
  // Durations packed {choc,milk,sugar,coffee,water}; the two zero LSBs let 2*state index directly.
  function automatic logic [1:0] dur(input logic [1:0] t, input state_t s);
    logic [9:0] r;
    r = t == 2'd0 ? 10'b00_00_00_10_10 :
        t == 2'd1 ? 10'b00_00_01_10_10 :
        t == 2'd2 ? 10'b00_10_00_10_01 : 10'b10_01_00_10_01;
    return 2'({r, 2'b00} >> {s, 1'b0});
  endfunction
  function automatic state_t next_step(input logic [1:0] t, input state_t s);
    state_t n;
    n = DONE;
    for (int i = 5; i >= 1; i--)
      if (i > int'(s) && dur(t, state_t'(3'(i))) != 2'd0) n = state_t'(3'(i));
    return n;
  endfunction
  function automatic logic [3:0] sat(input logic [4:0] v);
    return v > 5'(MAX_CREDIT) ? 4'(MAX_CREDIT) : v[3:0];
  endfunction
  assign add_z   = {4'b0, bus.coin_100} + (bus.coin_500 ? 5'd5 : 5'd0);
  assign add_c   = {1'b0, bus.credit} + add_z;
  assign valid   = !bus.coffee_type[2];
  assign price   = {2'b0, bus.coffee_type[1:0]} + 4'd2;
  assign afford  = bus.credit >= price;
  assign cnt_nxt = cnt + {1'b0, bus.tick};
  assign hit     = state == DONE ? cnt_nxt == 2'(DONE_TICKS) : cnt_nxt == dur(ty, state);
  assign bus.water     = state == WATER;
  assign bus.coffee    = state == COFFEE;
  assign bus.sugar     = state == SUGAR;
  assign bus.milk      = state == MILK;
  assign bus.chocolate = state == CHOC;
  assign bus.busy      = state != IDLE;
  assign bus.finished  = state == DONE;
  always_ff @(posedge clock)
    if (!reset) begin
      state      <= IDLE;
      ty         <= 2'd0;
      cnt        <= 2'd0;
      bus.credit <= 4'd0;
      bus.change <= 4'd0;
      bus.reject <= 1'b0;
    end else begin
      bus.reject <= 1'b0;
      bus.credit <= sat(add_c);
      case (state)
        IDLE:
          if (bus.cancel) begin
            if (bus.credit != 4'd0) begin
              bus.change <= bus.credit;
              bus.credit <= sat(add_z);
              state      <= DONE;
            end
          end else if (bus.start) begin
            if (valid && afford) begin
              ty         <= bus.coffee_type[1:0];
              bus.change <= bus.credit - price;
              bus.credit <= sat(add_z);
              state      <= next_step(bus.coffee_type[1:0], IDLE);
            end else bus.reject <= 1'b1;
          end
        DONE: begin
          cnt <= hit ? 2'd0 : cnt_nxt;
          if (hit) begin
            state      <= IDLE;
            bus.change <= 4'd0;
          end
        end
        default: begin
          cnt <= hit ? 2'd0 : cnt_nxt;
          if (hit) state <= next_step(ty, state);
        end
      endcase
    end
endmodule

// File: tb/tb_brew_order_controller.sv
// tb_brew_order_controller: table-driven and scoreboard-checked cycle vectors for brew_order_controller
module tb_brew_order_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  brew_order_controller_if bus();
  brew_order_controller #(.MAX_CREDIT(15), .DONE_TICKS(2)) dut (.clock(clock), .reset(reset), .bus(bus));
  // input word {reset_n, coin_100, coin_500, type[2:0], start, cancel, tick}
  localparam logic [8:0] N   = 9'b1_00_000_000;
  localparam logic [8:0] C1  = 9'b1_10_000_000;
  localparam logic [8:0] C5  = 9'b1_01_000_000;
  localparam logic [8:0] TK  = 9'b1_00_000_001;
  localparam logic [8:0] CN  = 9'b1_00_000_010;
  localparam logic [8:0] S0  = 9'b1_00_000_100;
  localparam logic [8:0] S2  = 9'b1_00_010_100;
  localparam logic [8:0] S3  = 9'b1_00_011_100;
  localparam logic [8:0] S6  = 9'b1_00_110_100;
  localparam logic [8:0] SC  = 9'b1_00_010_110;
  localparam logic [8:0] TC1 = 9'b1_10_000_001;
  localparam logic [8:0] R0  = 9'b0_00_000_001;
  localparam logic [8:0] RC  = 9'b0_11_000_000;
  localparam logic [8:0] RC5 = 9'b0_01_000_000;
  localparam logic [4:0] NV = 5'b00000, W = 5'b10000, CF = 5'b01000, SG = 5'b00100, MK = 5'b00010, CH = 5'b00001;
  localparam logic [2:0] I = 3'b000, B = 3'b100, R = 3'b010, D = 3'b101;
  typedef struct {
    logic [8:0]  in;
    logic [15:0] ex;
    string       nm;
  } vec_t;
  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  string       name_q[$];
  int total = 0;
  int bad = 0;
  function automatic logic [15:0] e(input int cr, input int ch, input logic [4:0] v, input logic [2:0] f);
    return {4'(cr), 4'(ch), v, f};
  endfunction
  function automatic logic [15:0] got();
    return {bus.credit, bus.change, bus.water, bus.coffee, bus.sugar, bus.milk, bus.chocolate,
            bus.busy, bus.reject, bus.finished};
  endfunction
  task automatic cyc(input logic [8:0] in, input logic [15:0] ex, input string nm);
    logic [15:0] g, x;
    string n;
    @(negedge clock);
    {reset, bus.coin_100, bus.coin_500, bus.coffee_type, bus.start, bus.cancel, bus.tick} = in;
    exp_q.push_back(ex);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
    g = got();
    x = exp_q.pop_front();
    n = name_q.pop_front();
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s: got cr=%0d ch=%0d v=%b bsy/rej/fin=%b, want cr=%0d ch=%0d v=%b bsy/rej/fin=%b",
               n, g[15:12], g[11:8], g[7:3], g[2:0], x[15:12], x[11:8], x[7:3], x[2:0]);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    {bus.coin_100, bus.coin_500, bus.coffee_type, bus.start, bus.cancel, bus.tick} = '0;
    tbl.push_back('{RC,  e(0, 0, NV, I),  "reset_coins0"});
    tbl.push_back('{RC5, e(0, 0, NV, I),  "reset_coins1"});
    tbl.push_back('{C5,  e(5, 0, NV, I),  "sat_5"});
    tbl.push_back('{C5,  e(10, 0, NV, I), "sat_10"});
    tbl.push_back('{C5,  e(15, 0, NV, I), "sat_15"});
    tbl.push_back('{C5 | C1, e(15, 0, NV, I), "sat_hold"});
    tbl.push_back('{CN,  e(0, 15, NV, D), "cancel15"});
    tbl.push_back('{TK,  e(0, 15, NV, D), "cancel15_done1"});
    tbl.push_back('{TK,  e(0, 0, NV, I),  "cancel15_idle"});
    tbl.push_back('{C5,  e(5, 0, NV, I),  "black_credit"});
    tbl.push_back('{S0,  e(0, 3, W, B),   "black_start"});
    tbl.push_back('{N,   e(0, 3, W, B),   "black_water_wait"});
    tbl.push_back('{TK,  e(0, 3, W, B),   "black_water_t1"});
    tbl.push_back('{TK,  e(0, 3, CF, B),  "black_coffee"});
    tbl.push_back('{TK,  e(0, 3, CF, B),  "black_coffee_t1"});
    tbl.push_back('{TK,  e(0, 3, NV, D),  "black_done"});
    tbl.push_back('{TK,  e(0, 3, NV, D),  "black_done_t1"});
    tbl.push_back('{TK,  e(0, 0, NV, I),  "black_idle"});
    tbl.push_back('{C1,  e(1, 0, NV, I),  "rej_c1"});
    tbl.push_back('{C1,  e(2, 0, NV, I),  "rej_c2"});
    tbl.push_back('{S3,  e(2, 0, NV, R),  "reject_poor"});
    tbl.push_back('{N,   e(2, 0, NV, I),  "reject_pulse_end"});
    tbl.push_back('{C1,  e(3, 0, NV, I),  "rej_c3"});
    tbl.push_back('{C1,  e(4, 0, NV, I),  "rej_c4"});
    tbl.push_back('{C1,  e(5, 0, NV, I),  "rej_c5"});
    tbl.push_back('{S6,  e(5, 0, NV, R),  "reject_type6"});
    tbl.push_back('{N,   e(5, 0, NV, I),  "reject_type6_end"});
    foreach (tbl[k]) cyc(tbl[k].in, tbl[k].ex, tbl[k].nm);
    // mocha: sugar step skipped, change 0
    cyc(S3, e(0, 0, W, B),  "mocha_water");
    cyc(TK, e(0, 0, CF, B), "mocha_coffee");
    cyc(TK, e(0, 0, CF, B), "mocha_coffee_t1");
    cyc(TK, e(0, 0, MK, B), "mocha_milk");
    cyc(TK, e(0, 0, CH, B), "mocha_choc");
    cyc(TK, e(0, 0, CH, B), "mocha_choc_t1");
    cyc(TK, e(0, 0, NV, D), "mocha_done");
    cyc(TK, e(0, 0, NV, D), "mocha_done_t1");
    cyc(TK, e(0, 0, NV, I), "mocha_idle");
    // cancel with credit 4; start/cancel ignored in DONE
    cyc(C1, e(1, 0, NV, I), "cn_c1");
    cyc(C1, e(2, 0, NV, I), "cn_c2");
    cyc(C1, e(3, 0, NV, I), "cn_c3");
    cyc(C1, e(4, 0, NV, I), "cn_c4");
    cyc(CN, e(0, 4, NV, D), "cancel4");
    cyc(SC, e(0, 4, NV, D), "done_ignores_cmds");
    cyc(TK, e(0, 4, NV, D), "cancel4_t1");
    cyc(TK, e(0, 0, NV, I), "cancel4_idle");
    cyc(CN, e(0, 0, NV, I), "cancel_zero_ignored");
    // latte with mid-brew commands, coin, then reset in MILK
    cyc(C5,  e(5, 0, NV, I), "latte_credit");
    cyc(S2,  e(0, 1, W, B),  "latte_water");
    cyc(SC,  e(0, 1, W, B),  "latte_ignore_cmds");
    cyc(TC1, e(1, 1, CF, B), "latte_coin_coffee");
    cyc(CN,  e(1, 1, CF, B), "latte_ignore_cancel");
    cyc(TK,  e(1, 1, CF, B), "latte_coffee_t1");
    cyc(TK,  e(1, 1, MK, B), "latte_milk");
    cyc(TK,  e(1, 1, MK, B), "latte_milk_t1");
    cyc(R0,  e(0, 0, NV, I), "reset_in_milk");
    cyc(TK,  e(0, 0, NV, I), "after_reset_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
